// File: rtl/dmem_responder.sv
// Data-memory responder: word array with wait states, req/ready handshake,
// little-endian byte/half/word stores, sign/zero-extended loads, misalign flag.
// Ports: clk, reset (sync, active-high); request side req, we, addr, size,
// unsign, wdata; response side rdata (registered), ready (1-cycle strobe),
// misalign (valid with ready).
module dmem_responder #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        unsign,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misalign
);

  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WC    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W+1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem_q [DEPTH];

  logic              accept;
  logic              serve;
  logic              mis;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic [31:0]       word;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_val;
  logic [31:0]       wr_val;
  logic [3:0]        be;

  // High address bits alias; they are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign accept = (state_q == IDLE) && req;
  assign serve  = (state_q == WAIT) && (cnt_q == 4'd0);
  assign widx   = addr_q[ADDR_W+1:2];
  assign lane   = addr_q[1:0];

  assign mis = (size_q == 2'b11)
             | ((size_q == 2'b01) & addr_q[0])
             | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00));

  assign word = mem_q[widx];
  assign ld_b = word[{lane, 3'b000} +: 8];
  assign ld_h = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_val = word;
    be     = 4'b1111;
    wr_val = wdata_q;
    unique case (size_q)
      2'b00: begin
        ld_val = {{24{~uns_q & ld_b[7]}}, ld_b};
        be     = 4'b0001 << lane;
        wr_val = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ld_val = {{16{~uns_q & ld_h[15]}}, ld_h};
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wr_val = {2{wdata_q[15:0]}};
      end
      default: begin
        ld_val = word;
        be     = 4'b1111;
        wr_val = wdata_q;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request latch and array; the array is never cleared by reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr[ADDR_W+1:0];
      we_q    <= we;
      size_q  <= size;
      uns_q   <= unsign;
      wdata_q <= wdata;
    end
    if (serve && we_q && !mis && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wr_val[8*i +: 8];
      end
    end
  end

  // Next state. The counter is loaded with WAIT_CYCLES and RESP is
  // entered at the edge that sees it at zero, so a request accepted at
  // edge N enters RESP at edge N+1+WAIT_CYCLES (also for zero waits).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          cnt_d   = WC;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = (we_q || mis) ? 32'd0 : ld_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready    = (state_q == RESP);
    misalign = (state_q == RESP) & mis;
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances share
// stimulus; a byte-array timing model is compared every cycle.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        unsign;
  logic [31:0] wdata;

  logic [31:0] rd  [2];
  logic        rdy [2];
  logic        msw [2];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .size(size), .unsign(unsign), .wdata(wdata),
    .rdata(rd[0]), .ready(rdy[0]), .misalign(msw[0])
  );

  dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .size(size), .unsign(unsign), .wdata(wdata),
    .rdata(rd[1]), .ready(rdy[1]), .misalign(msw[1])
  );

  function automatic int wt(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  // Model: a byte array of 256 bytes per instance; a request accepted
  // at edge N is served at edge N+1+W, responds for one cycle, and the
  // instance accepts again only after the response cycle has ended.
  int          cyc = 0;
  bit          started = 0;
  bit          busy [2];
  int          done [2];
  bit          er   [2];
  bit          em   [2];
  logic [31:0] erd  [2];
  logic [7:0]  mm   [2][256];
  bit          p_we [2];
  logic [31:0] p_a  [2];
  logic [1:0]  p_sz [2];
  bit          p_u  [2];
  logic [31:0] p_d  [2];

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        busy[k] = 0;
        er[k]   = 0;
        em[k]   = 0;
        erd[k]  = 32'd0;
      end else begin
        er[k] = 0;
        if (busy[k] && cyc == done[k] + 1) begin
          busy[k] = 0;
        end else if (busy[k] && cyc == done[k]) begin
          int a, n;
          bit m;
          logic [31:0] v;
          a = int'(p_a[k][7:0]);
          n = 1 << p_sz[k];
          m = (p_sz[k] == 3) || (p_sz[k] == 1 && a % 2 != 0)
           || (p_sz[k] == 2 && a % 4 != 0);
          er[k]  = 1;
          em[k]  = m;
          erd[k] = 32'd0;
          if (!m && p_we[k]) begin
            for (int i = 0; i < n; i++)
              mm[k][(a + i) % 256] = p_d[k][8*i +: 8];
          end else if (!m) begin
            v = 32'd0;
            for (int i = 0; i < n; i++)
              v[8*i +: 8] = mm[k][(a + i) % 256];
            if (n < 4 && !p_u[k] && v[8*n-1])
              for (int j = 8 * n; j < 32; j++) v[j] = 1'b1;
            erd[k] = v;
          end
        end else if (!busy[k] && req) begin
          busy[k] = 1;
          done[k] = cyc + 1 + wt(k);
          p_we[k] = we;
          p_a[k]  = addr;
          p_sz[k] = size;
          p_u[k]  = unsign;
          p_d[k]  = wdata;
        end
      end
    end
    if (reset) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (rdy[k] !== er[k]) begin
          errs++;
          $display("FAIL cyc%0d u%0d ready: got %b want %b",
                   cyc, k, rdy[k], er[k]);
        end
        vecs++;
        if (rd[k] !== erd[k]) begin
          errs++;
          $display("FAIL cyc%0d u%0d rdata: got %h want %h",
                   cyc, k, rd[k], erd[k]);
        end
        if (er[k]) begin
          vecs++;
          if (msw[k] !== em[k]) begin
            errs++;
            $display("FAIL cyc%0d u%0d misalign: got %b want %b",
                     cyc, k, msw[k], em[k]);
          end
        end
      end
    end
  end

  task automatic chk32(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // One transaction on both instances. Inputs are scrambled right after
  // acceptance; abort pulses reset while the request is in flight.
  task automatic op(input string nm, input bit w, input logic [31:0] a,
                    input logic [1:0] sz, input bit u,
                    input logic [31:0] d, input bit abort,
                    input logic [31:0] xr, input bit xm);
    int l2, l0;
    logic [31:0] r2, r0;
    bit m2, m0;
    @(negedge clk);
    req = 1; we = w; addr = a; size = sz; unsign = u; wdata = d;
    @(negedge clk);
    req = 0; we = ~w; addr = ~a; size = ~sz; unsign = ~u; wdata = ~d;
    if (abort) reset = 1;
    l2 = -1; l0 = -1;
    r2 = 32'd0; r0 = 32'd0; m2 = 0; m0 = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      reset = 0;
      if (rdy[1] && l2 < 0) begin l2 = n; r2 = rd[1]; m2 = msw[1]; end
      if (rdy[0] && l0 < 0) begin l0 = n; r0 = rd[0]; m0 = msw[0]; end
    end
    chki({nm, " lat W2"}, l2, abort ? -1 : 3);
    chki({nm, " lat W0"}, l0, abort ? -1 : 1);
    if (!abort) begin
      chk32({nm, " rdata W2"}, r2, xr);
      chk32({nm, " rdata W0"}, r0, xr);
      chki({nm, " mis W2"}, int'(m2), int'(xm));
      chki({nm, " mis W0"}, int'(m0), int'(xm));
    end
  endtask

  initial begin
    reset = 1; req = 0; we = 0; addr = 0;
    size = 0; unsign = 0; wdata = 0;
    repeat (3) @(negedge clk);
    chki("reset ready", int'(rdy[1]), 0);
    chk32("reset rdata", rd[1], 32'd0);
    reset = 0;

    op("sw 10", 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, 32'h0, 0);
    op("lw 10", 0, 32'h10, 2'b10, 0, 32'h0, 0, 32'hDEADBEEF, 0);

    op("sw 20", 1, 32'h20, 2'b10, 0, 32'h0, 0, 32'h0, 0);
    op("sb 21", 1, 32'h21, 2'b00, 0, 32'hFFFFFF80, 0, 32'h0, 0);
    op("lb 21", 0, 32'h21, 2'b00, 0, 32'h0, 0, 32'hFFFFFF80, 0);
    op("lbu 21", 0, 32'h21, 2'b00, 1, 32'h0, 0, 32'h00000080, 0);
    op("lw 20", 0, 32'h20, 2'b10, 0, 32'h0, 0, 32'h00008000, 0);
    op("sb 23", 1, 32'h23, 2'b00, 0, 32'h000000FE, 0, 32'h0, 0);
    op("lw 20b", 0, 32'h20, 2'b10, 1, 32'h0, 0, 32'hFE008000, 0);

    op("sw 30", 1, 32'h30, 2'b10, 0, 32'hCAFEBABE, 0, 32'h0, 0);
    op("sh 32", 1, 32'h32, 2'b01, 0, 32'h12348001, 0, 32'h0, 0);
    op("lh 32", 0, 32'h32, 2'b01, 0, 32'h0, 0, 32'hFFFF8001, 0);
    op("lhu 32", 0, 32'h32, 2'b01, 1, 32'h0, 0, 32'h00008001, 0);
    op("lw 30", 0, 32'h30, 2'b10, 0, 32'h0, 0, 32'h8001BABE, 0);

    op("sw 40", 1, 32'h40, 2'b10, 0, 32'h11223344, 0, 32'h0, 0);
    op("sw 41", 1, 32'h41, 2'b10, 0, 32'hFFFFFFFF, 0, 32'h0, 1);
    op("lh 43", 0, 32'h43, 2'b01, 0, 32'h0, 0, 32'h0, 1);
    op("sz 11", 1, 32'h40, 2'b11, 0, 32'h0, 0, 32'h0, 1);
    op("lw 40", 0, 32'h40, 2'b10, 0, 32'h0, 0, 32'h11223344, 0);

    op("sw 00", 1, 32'h00, 2'b10, 0, 32'hA5A5A5A5, 0, 32'h0, 0);
    op("sw 100", 1, 32'h100, 2'b10, 0, 32'h5A5A5A5A, 0, 32'h0, 0);
    op("lw 00", 0, 32'h00, 2'b10, 0, 32'h0, 0, 32'h5A5A5A5A, 0);

    op("sw 50", 1, 32'h50, 2'b10, 0, 32'h0BADF00D, 0, 32'h0, 0);
    op("abort", 1, 32'h50, 2'b10, 0, 32'h12345678, 1, 32'h0, 0);
    op("lw 50", 0, 32'h50, 2'b10, 0, 32'h0, 0, 32'h0BADF00D, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
